// File: rtl/diffuser_pkg.sv
// Shared encodings for the scent diffuser pump scheduler: FSM states,
// scent codes, session timer codes and the timer-to-minutes table.
package diffuser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPRAY  = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_MANUAL = 2'd3
  } state_t;

  localparam logic [1:0] SCENT_COTTON = 2'd0;
  localparam logic [1:0] SCENT_WOODY  = 2'd1;
  localparam logic [1:0] SCENT_CITRUS = 2'd2;

  localparam logic [1:0] TIMER_30  = 2'd0;
  localparam logic [1:0] TIMER_60  = 2'd1;
  localparam logic [1:0] TIMER_120 = 2'd2;

  localparam int REMAIN_W = 7;

  // Session length in minutes; the unused code 3 falls back to 30 min.
  function automatic logic [REMAIN_W-1:0] timer_minutes(input logic [1:0] sel);
    case (sel)
      TIMER_60:  return 7'd60;
      TIMER_120: return 7'd120;
      default:   return 7'd30;
    endcase
  endfunction

  // Scent code 3 is undefined and is treated as Cotton.
  function automatic logic [1:0] scent_norm(input logic [1:0] sel);
    return (sel == 2'd3) ? SCENT_COTTON : sel;
  endfunction

  // One-hot pump select; bit index equals the scent code.
  function automatic logic [2:0] scent_onehot(input logic [1:0] code);
    case (code)
      SCENT_WOODY:  return 3'b010;
      SCENT_CITRUS: return 3'b100;
      default:      return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Second prescaler: tick is high for one cycle every CLK_HZ cycles,
// counted from the last restart (restart clears the count).
module sec_tick_gen #(
  parameter int CLK_HZ = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count_q;

  // Free-running cycle counter that wraps at CLK_HZ and restarts on demand.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (restart || (count_q == CNT_LAST)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tick = (count_q == CNT_LAST);

endmodule

// File: rtl/pump_scheduler.sv
// Scent diffuser pump scheduler: timed spray/pause sessions with a
// minute countdown, single manual sprays, and one-hot pump drive.
module pump_scheduler
  import diffuser_pkg::*;
#(
  parameter int CLK_HZ      = 1_000_000,
  parameter int MIN_S       = 60,
  parameter int SPRAY_ON_S  = 5,
  parameter int SPRAY_OFF_S = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pump_on,
  input  logic       pump_off,
  input  logic       manual_on,
  input  logic [1:0] scent_sel,
  input  logic [1:0] timer_sel,
  output logic [2:0] pump_en,
  output logic       busy,
  output logic [1:0] state,
  output logic [6:0] remain_min,
  output logic       done
);

  localparam int PH_MAX = (SPRAY_ON_S > SPRAY_OFF_S) ? SPRAY_ON_S : SPRAY_OFF_S;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int SUB_W  = (MIN_S > 1) ? $clog2(MIN_S) : 1;

  localparam logic [PH_W-1:0]  PH_ON    = PH_W'(SPRAY_ON_S);
  localparam logic [PH_W-1:0]  PH_OFF   = PH_W'(SPRAY_OFF_S);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(MIN_S - 1);

  state_t                state_q, state_n;
  logic [PH_W-1:0]       phase_q, phase_n;
  logic [SUB_W-1:0]      sub_q, sub_n;
  logic [1:0]            scent_q, scent_n;
  logic [REMAIN_W-1:0]   remain_q, remain_n;
  logic [2:0]            pump_en_q, pump_en_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  restart;
  logic                  tick;
  logic                  minute_wrap;

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      sub_q     <= '0;
      scent_q   <= '0;
      remain_q  <= '0;
      pump_en_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      phase_q   <= phase_n;
      sub_q     <= sub_n;
      scent_q   <= scent_n;
      remain_q  <= remain_n;
      pump_en_q <= pump_en_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Next-state logic: stop beats start, start beats manual, and session
  // expiry beats a coincident phase expiry.
  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    sub_n       = sub_q;
    scent_n     = scent_q;
    remain_n    = remain_q;
    done_n      = 1'b0;
    restart     = 1'b0;
    minute_wrap = (sub_q == SUB_LAST);

    if (pump_off) begin
      state_n  = ST_IDLE;
      phase_n  = '0;
      sub_n    = '0;
      remain_n = '0;
    end else if (pump_on) begin
      restart  = 1'b1;
      state_n  = ST_SPRAY;
      phase_n  = PH_ON;
      sub_n    = '0;
      remain_n = timer_minutes(timer_sel);
      scent_n  = scent_norm(scent_sel);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (manual_on) begin
            restart = 1'b1;
            state_n = ST_MANUAL;
            phase_n = PH_ON;
            scent_n = scent_norm(scent_sel);
          end
        end
        ST_SPRAY, ST_PAUSE: begin
          if (tick) begin
            sub_n = minute_wrap ? '0 : sub_q + SUB_W'(1);
            if (minute_wrap) begin
              remain_n = remain_q - REMAIN_W'(1);
            end
            if (minute_wrap && (remain_q <= REMAIN_W'(1))) begin
              state_n  = ST_IDLE;
              phase_n  = '0;
              sub_n    = '0;
              remain_n = '0;
              done_n   = 1'b1;
            end else if (phase_q <= PH_ONE) begin
              if (state_q == ST_SPRAY) begin
                state_n = ST_PAUSE;
                phase_n = PH_OFF;
              end else begin
                state_n = ST_SPRAY;
                phase_n = PH_ON;
                scent_n = scent_norm(scent_sel);
              end
            end else begin
              phase_n = phase_q - PH_ONE;
            end
          end
        end
        ST_MANUAL: begin
          if (tick) begin
            if (phase_q <= PH_ONE) begin
              state_n = ST_IDLE;
              phase_n = '0;
            end else begin
              phase_n = phase_q - PH_ONE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    pump_en_n = ((state_n == ST_SPRAY) || (state_n == ST_MANUAL))
                ? scent_onehot(scent_n) : 3'b000;
    busy_n    = (state_n != ST_IDLE);
  end

  assign pump_en    = pump_en_q;
  assign busy       = busy_q;
  assign state      = state_q;
  assign remain_min = remain_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pump_scheduler.sv
// Self-checking bench for pump_scheduler with shortened timing
// (10 cycles per second, 4 seconds per minute, 1 s spray, 2 s pause).
module tb_pump_scheduler;

  localparam int CLK_HZ = 10;
  localparam int MIN_S  = 4;
  localparam int ON_S   = 1;
  localparam int OFF_S  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pump_on = 1'b0;
  logic       pump_off = 1'b0;
  logic       manual_on = 1'b0;
  logic [1:0] scent_sel = 2'd0;
  logic [1:0] timer_sel = 2'd0;
  logic [2:0] pump_en;
  logic       busy;
  logic [1:0] state;
  logic [6:0] remain_min;
  logic       done;

  int checks = 0;
  int passes = 0;

  // Reference model: session described by elapsed cycles since start.
  int m_mode = 0;   // 0 idle, 1 timed session, 2 manual spray
  int m_k = 0;
  int m_total = 0;
  int m_scent = 0;
  int m_done = 0;

  pump_scheduler #(
    .CLK_HZ      (CLK_HZ),
    .MIN_S       (MIN_S),
    .SPRAY_ON_S  (ON_S),
    .SPRAY_OFF_S (OFF_S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pump_on    (pump_on),
    .pump_off   (pump_off),
    .manual_on  (manual_on),
    .scent_sel  (scent_sel),
    .timer_sel  (timer_sel),
    .pump_en    (pump_en),
    .busy       (busy),
    .state      (state),
    .remain_min (remain_min),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int t_minutes(input logic [1:0] tm);
    case (tm)
      2'd1: return 60;
      2'd2: return 120;
      default: return 30;
    endcase
  endfunction

  function automatic int t_norm(input logic [1:0] sc);
    return (sc == 2'd3) ? 0 : int'(sc);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_total = 0; m_scent = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit on, input bit off, input bit man,
                            input logic [1:0] sc, input logic [1:0] tm);
    m_done = 0;
    if (off) m_mode = 0;
    else if (on) begin
      m_mode = 1; m_k = 0; m_total = t_minutes(tm); m_scent = t_norm(sc);
    end else if (m_mode == 0) begin
      if (man) begin m_mode = 2; m_k = 0; m_scent = t_norm(sc); end
    end else if (m_mode == 1) begin
      m_k++;
      if (m_k == m_total * MIN_S * CLK_HZ) begin m_mode = 0; m_done = 1; end
      else if (m_k % (CLK_HZ * (ON_S + OFF_S)) == 0) m_scent = t_norm(sc);
    end else begin
      m_k++;
      if (m_k == ON_S * CLK_HZ) m_mode = 0;
    end
  endtask

  task automatic model_check(input string name);
    int st, en, rem;
    st = 0; en = 0; rem = 0;
    if (m_mode == 1) begin
      st  = (((m_k / CLK_HZ) % (ON_S + OFF_S)) < ON_S) ? 1 : 2;
      rem = m_total - m_k / (MIN_S * CLK_HZ);
    end else if (m_mode == 2) st = 3;
    if (st == 1 || st == 3) en = 1 << m_scent;
    chk(name, {state, pump_en, remain_min, done, busy},
        {st[1:0], en[2:0], rem[6:0], m_done[0], (st != 0)});
    chk("onehot", ($countones(pump_en) <= 1), 1);
  endtask

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic step();
    bit on, off, man;
    logic [1:0] sc, tm;
    on = pump_on; off = pump_off; man = manual_on; sc = scent_sel; tm = timer_sel;
    @(posedge clk);
    if (reset) model_edge(on, off, man, sc, tm);
    else model_reset();
    #1;
  endtask

  task automatic pulse(input bit on, input bit off, input bit man,
                       input logic [1:0] sc, input logic [1:0] tm);
    pump_on = on; pump_off = off; manual_on = man; scent_sel = sc; timer_sel = tm;
    step();
    pump_on = 1'b0; pump_off = 1'b0; manual_on = 1'b0;
  endtask

  typedef struct {
    bit on; bit off; bit man;
    logic [1:0] sc; logic [1:0] tm;
    logic [2:0] en; logic [1:0] st; logic [6:0] rem; bit dn;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int dcount;
    tbl[0]  = '{0, 0, 0, 2'd0, 2'd0, 3'b000, 2'd0, 7'd0,   0};
    tbl[1]  = '{1, 0, 0, 2'd2, 2'd0, 3'b100, 2'd1, 7'd30,  0};
    tbl[2]  = '{0, 0, 0, 2'd2, 2'd0, 3'b100, 2'd1, 7'd30,  0};
    tbl[3]  = '{0, 0, 1, 2'd1, 2'd0, 3'b100, 2'd1, 7'd30,  0};
    tbl[4]  = '{0, 1, 0, 2'd2, 2'd0, 3'b000, 2'd0, 7'd0,   0};
    tbl[5]  = '{1, 1, 0, 2'd2, 2'd1, 3'b000, 2'd0, 7'd0,   0};
    tbl[6]  = '{0, 0, 1, 2'd1, 2'd0, 3'b010, 2'd3, 7'd0,   0};
    tbl[7]  = '{1, 0, 0, 2'd3, 2'd3, 3'b001, 2'd1, 7'd30,  0};
    tbl[8]  = '{1, 0, 0, 2'd1, 2'd2, 3'b010, 2'd1, 7'd120, 0};
    tbl[9]  = '{1, 0, 0, 2'd0, 2'd1, 3'b001, 2'd1, 7'd60,  0};
    tbl[10] = '{0, 1, 0, 2'd0, 2'd0, 3'b000, 2'd0, 7'd0,   0};

    // Reset held, then released with no stimulus.
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset", {state, pump_en, remain_min, done, busy}, 14'd0);
    reset = 1'b1;
    step();
    chk("after_reset", {state, pump_en, remain_min, done, busy}, 14'd0);

    // Single-cycle vector table.
    for (int i = 0; i < 11; i++) begin
      pulse(tbl[i].on, tbl[i].off, tbl[i].man, tbl[i].sc, tbl[i].tm);
      chk($sformatf("vec%0d", i), {state, pump_en, remain_min, done, busy},
          {tbl[i].st, tbl[i].en, tbl[i].rem, tbl[i].dn, (tbl[i].st != 2'd0)});
    end

    // Full 30 minute session with Citrus through to natural expiry.
    dcount = 0;
    pulse(1, 0, 0, 2'd2, 2'd0);
    chk("sess_start_en", pump_en, 3'b100);
    chk("sess_start_rem", remain_min, 7'd30);
    for (int i = 1; i <= 1205; i++) begin
      step();
      dcount += int'(done);
      if (i == 9)    chk("spray_last", pump_en, 3'b100);
      if (i == 10)   chk("pause_first", {state, pump_en}, {2'd2, 3'b000});
      if (i == 29)   chk("pause_last", {state, pump_en}, {2'd2, 3'b000});
      if (i == 30)   chk("spray_again", {state, pump_en}, {2'd1, 3'b100});
      if (i == 39)   chk("rem_before_min", remain_min, 7'd30);
      if (i == 40)   chk("rem_after_min", remain_min, 7'd29);
      if (i == 1199) chk("pre_expiry", {state, remain_min, done}, {2'd2, 7'd1, 1'b0});
      if (i == 1200) chk("expiry", {state, pump_en, remain_min, done, busy},
                         {2'd0, 3'b000, 7'd0, 1'b1, 1'b0});
      if (i == 1201) chk("done_one_cycle", done, 1'b0);
    end
    chk("done_count", dcount, 1);

    // Scent change mid-spray only applies at the next spray entry.
    pulse(1, 0, 0, 2'd0, 2'd1);
    for (int i = 1; i <= 31; i++) begin
      if (i == 3) scent_sel = 2'd1;
      step();
      if (i == 9)  chk("scent_hold", pump_en, 3'b001);
      if (i == 10) chk("scent_pause", pump_en, 3'b000);
      if (i == 30) chk("scent_new", pump_en, 3'b010);
    end
    pulse(0, 1, 0, 2'd0, 2'd0);
    chk("stop_no_done", {state, pump_en, remain_min, done, busy}, 14'd0);

    // Manual spray with Woody.
    dcount = 0;
    pulse(0, 0, 1, 2'd1, 2'd0);
    chk("man_start", {state, pump_en, remain_min}, {2'd3, 3'b010, 7'd0});
    for (int i = 1; i <= 12; i++) begin
      step();
      dcount += int'(done);
      if (i == 9)  chk("man_last", {state, pump_en}, {2'd3, 3'b010});
      if (i == 10) chk("man_end", {state, pump_en, busy}, {2'd0, 3'b000, 1'b0});
    end
    chk("man_no_done", dcount, 0);

    // Asynchronous reset during PAUSE with 17 minutes left.
    pulse(1, 0, 0, 2'd1, 2'd0);
    repeat (525) step();
    chk("pre_reset_pause", {state, remain_min}, {2'd2, 7'd17});
    reset = 1'b0;
    #1;
    chk("async_reset", {state, pump_en, remain_min, done, busy}, 14'd0);
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();
    chk("post_reset", {state, pump_en, remain_min, done, busy}, 14'd0);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 9000; i++) begin
      pump_on   = ($urandom_range(1499) == 0);
      pump_off  = ($urandom_range(2499) == 0);
      manual_on = ($urandom_range(59) == 0);
      scent_sel = 2'($urandom_range(3));
      timer_sel = 2'($urandom_range(3));
      step();
      model_check("random");
    end
    pump_on = 1'b0; pump_off = 1'b0; manual_on = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pump_scheduler.md
PUMP_SCHEDULER -- requirements
Module: pump_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1_000_000, clock cycles per second.
REQ-002 SHALL have parameter MIN_S, default 60, seconds per session minute (reduced in simulation).
REQ-003 SHALL have parameter SPRAY_ON_S, default 5, spray phase length in seconds.
REQ-004 SHALL have parameter SPRAY_OFF_S, default 25, pause phase length in seconds.
REQ-005 SHALL have ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- pump_on  in  1  one-cycle start/restart-session pulse.
- pump_off  in  1  one-cycle stop pulse.
- manual_on  in  1  one-cycle single-spray request.
- scent_sel  in  2  0 Cotton, 1 Woody, 2 Citrus.
- timer_sel  in  2  0 = 30 min, 1 = 60 min, 2 = 120 min.
- pump_en  out  3  one-hot pump drive, bit index = scent code.
- busy  out  1  state not IDLE.
- state  out  2  0 IDLE, 1 SPRAY, 2 PAUSE, 3 MANUAL.
- remain_min  out  7  session minutes remaining.
- done  out  1  one-cycle pulse on natural session expiry.

Function
REQ-006 SHALL register all outputs; each input event is visible on the outputs in the cycle after it is sampled.
REQ-007 SHALL, in IDLE on pump_on, load remain_min from timer_sel (30/60/120), restart the second prescaler and the minute sub-counter, and enter SPRAY with the phase counter set to SPRAY_ON_S.
REQ-008 SHALL treat scent_sel = 3 as 0 and timer_sel = 3 as 0.
REQ-009 SHALL, in SPRAY, drive pump_en = one-hot(latched scent); in PAUSE and IDLE, drive pump_en = 0.
REQ-010 SHALL latch scent_sel on every entry to SPRAY or MANUAL; a scent change mid-phase takes effect at the next SPRAY entry only.
REQ-011 SHALL switch from SPRAY to PAUSE (phase counter set to SPRAY_OFF_S) when the SPRAY phase expires, and from PAUSE to SPRAY when the PAUSE phase expires.
REQ-012 SHALL decrement the phase counter on each second tick, where a second tick is one every CLK_HZ cycles from the prescaler restart.
REQ-013 SHALL, in SPRAY or PAUSE, decrement remain_min once every MIN_S second ticks; when remain_min reaches 0, go to IDLE, clear pump_en, and pulse done for one cycle.
REQ-014 SHALL, on pump_off in any state, enter IDLE next cycle with pump_en = 0 and remain_min = 0, and SHALL NOT pulse done.
REQ-015 SHALL give pump_off priority over pump_on and manual_on in the same cycle.
REQ-016 SHALL, on pump_on in SPRAY, PAUSE or MANUAL, restart the session exactly as in REQ-007.
REQ-017 SHALL, on manual_on in IDLE, enter MANUAL, drive pump_en = one-hot(scent) for SPRAY_ON_S seconds, then return to IDLE with no done pulse; remain_min stays 0.
REQ-018 SHALL ignore manual_on in SPRAY, PAUSE and MANUAL.
REQ-019 SHALL, when a phase expiry and session expiry coincide, apply session expiry (IDLE).
REQ-020 SHALL keep pump_en one-hot or zero in every cycle.

Reset
REQ-021 SHALL, while reset = 0, asynchronously force:
- state IDLE.
- pump_en, busy, done, remain_min to 0.
- All counters and the latched scent to 0.
REQ-022 SHALL abort any active session on reset, with no done pulse.

Structure
REQ-023 SHALL place in package diffuser_pkg:
- State encodings.
- Scent codes.
- Timer codes and the 30/60/120 minute table.
REQ-024 SHALL implement the second prescaler as sub-module sec_tick_gen (inputs clk, reset, restart; output tick).
REQ-025 SHALL size counters from the parameters, with no truncation at the default values.

Verification (CLK_HZ=10, MIN_S=4, SPRAY_ON_S=1, SPRAY_OFF_S=2)
REQ-026 SHALL cover these directed scenarios:
- Reset released, no stimulus -> all outputs 0, state 0.
- pump_on with scent 2, timer 0 -> next cycle pump_en=100, remain_min=30; pump_en on 10 cycles / off 20 cycles repeating; remain_min decrements every 40 cycles; after 1200 cycles done=1 for one cycle, then state 0 and pump_en 0.
- pump_off in SPRAY -> next cycle pump_en 0, busy 0, remain_min 0, no done; pump_on with pump_off in the same cycle while IDLE -> stays IDLE.
- manual_on in IDLE with scent 1 -> pump_en=010 for 10 cycles then IDLE; a manual_on issued during SPRAY -> no effect.
- scent_sel changed 0 to 1 mid-SPRAY -> pump_en stays 001 until the phase ends, then 010 at the next SPRAY.
- reset pulled low mid-PAUSE with remain_min=17 -> all outputs 0 immediately, no done.
